// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential signed divider.
package div_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_e;

  localparam int DEF_N = 16;
  localparam int CNT_W = $clog2(DEF_N + 1);

endpackage

// File: rtl/div_controller.sv
// Divider FSM and iteration counter; drives the datapath held in seq_divider.
module div_controller
  import div_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic pre_err,
  input  logic ge,
  output logic ld,
  output logic sh,
  output logic sub,
  output logic fix,
  output logic err_set,
  output logic busy,
  output logic ready
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        state;
  logic [CW-1:0] cnt;

  assign ld      = ((state == IDLE) || (state == DONE)) && start;
  assign sh      = (state == ITER);
  assign sub     = sh && ge;
  assign fix     = (state == FIX);
  assign err_set = (state == LOAD) && pre_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= pre_err ? FIX : ITER;
        end
        ITER: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
        DONE: begin
          // A start here chains straight into the next division.
          if (start) begin
            state <= LOAD;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider, 2N/N -> N quotient and N remainder, one quotient
// bit per cycle by restoring iteration on magnitudes with a final sign fix-up.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  startDR,
  input  logic signed [2*N-1:0] Dvd,
  input  logic signed [N-1:0]   Dvs,
  output logic                  busy,
  output logic                  readyDR,
  output logic signed [N-1:0]   outQ,
  output logic signed [N-1:0]   outR,
  output logic                  errDR
);

  localparam logic [N-1:0] Q_POS_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] Q_NEG_MAX = {1'b1, {(N-1){1'b0}}};

  function automatic logic [2*N-1:0] mag_dvd(input logic signed [2*N-1:0] v);
    return v[2*N-1] ? -v : v;
  endfunction

  function automatic logic [N-1:0] mag_dvs(input logic signed [N-1:0] v);
    return v[N-1] ? -v : v;
  endfunction

  function automatic logic [N-1:0] apply_sign(input logic [N-1:0] mag, input logic neg);
    return neg ? -mag : mag;
  endfunction

  function automatic logic q_in_range(input logic [N-1:0] mag, input logic neg);
    return neg ? (mag <= Q_NEG_MAX) : (mag <= Q_POS_MAX);
  endfunction

  logic [2*N-1:0] dvd_abs;
  logic [N-1:0]   rem, lo, dvs_abs;
  logic [N:0]     rem_sh;
  logic           sign_q, sign_r, err_flag;
  logic           ld, sh, sub, fix, err_set, ge, pre_err;

  assign dvd_abs = mag_dvd(Dvd);
  assign rem_sh  = {rem, lo[N-1]};
  assign ge      = (rem_sh >= {1'b0, dvs_abs});
  // Upper dividend half already >= divisor means the quotient cannot fit in N bits.
  assign pre_err = (dvs_abs == '0) || (rem >= dvs_abs);

  div_controller #(.N(N), .CW($clog2(N + 1))) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (startDR),
    .pre_err (pre_err),
    .ge      (ge),
    .ld      (ld),
    .sh      (sh),
    .sub     (sub),
    .fix     (fix),
    .err_set (err_set),
    .busy    (busy),
    .ready   (readyDR)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem      <= '0;
      lo       <= '0;
      dvs_abs  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      err_flag <= 1'b0;
      outQ     <= '0;
      outR     <= '0;
      errDR    <= 1'b0;
    end else begin
      if (ld) begin
        rem      <= dvd_abs[2*N-1:N];
        lo       <= dvd_abs[N-1:0];
        dvs_abs  <= mag_dvs(Dvs);
        sign_q   <= Dvd[2*N-1] ^ Dvs[N-1];
        sign_r   <= Dvd[2*N-1];
        err_flag <= 1'b0;
      end
      if (err_set) err_flag <= 1'b1;
      // lo shifts dividend bits out the top while quotient bits enter the bottom.
      if (sh) begin
        rem <= sub ? (rem_sh[N-1:0] - dvs_abs) : rem_sh[N-1:0];
        lo  <= {lo[N-2:0], sub};
      end
      if (fix) begin
        if (err_flag || !q_in_range(lo, sign_q)) begin
          outQ  <= '0;
          outR  <= '0;
          errDR <= 1'b1;
        end else begin
          outQ  <= apply_sign(lo, sign_q);
          outR  <= apply_sign(rem, sign_r);
          errDR <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: arithmetic reference model plus literal pins.
module tb_seq_divider;

  localparam int N = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 startDR;
  logic [2*N-1:0]       Dvd;
  logic [N-1:0]         Dvs;
  logic                 busy, readyDR, errDR;
  logic [N-1:0]         outQ, outR;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    bit           err;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  seq_divider #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .startDR (startDR),
    .Dvd     (Dvd),
    .Dvs     (Dvs),
    .busy    (busy),
    .readyDR (readyDR),
    .outQ    (outQ),
    .outR    (outR),
    .errDR   (errDR)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain signed integer division, truncating toward zero.
  function automatic exp_t model(input logic [2*N-1:0] a, input logic [N-1:0] b);
    exp_t   m;
    longint sa, sb, q, r, ma, mb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m.start_cyc = 0;
    if (sb == 0) begin
      m.q = '0; m.r = '0; m.err = 1'b1; m.lat = 2;
      return m;
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q  = sa / sb;
    r  = sa % sb;
    m.lat = (ma >= (mb << N)) ? 2 : N + 2;
    m.err = (q > 32767) || (q < -32768);
    if (m.err) begin
      m.q = '0; m.r = '0;
    end else begin
      m.q = q[N-1:0]; m.r = r[N-1:0];
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (readyDR) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ready: readyDR=1 with nothing outstanding (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("model_q",   outQ,  mon_e.q);
          check("model_r",   outR,  mon_e.r);
          check("model_err", errDR, mon_e.err);
          check("latency",   cyc - mon_e.start_cyc, mon_e.lat);
          check("busy_on_ready", busy, 1'b0);
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].start_cyc) begin
        check("busy_during_op", busy, 1'b1);
      end
    end
  end

  task automatic start_op(input logic [2*N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    Dvd = a;
    Dvs = b;
    startDR = 1'b1;
    e = model(a, b);
    e.start_cyc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 startDR = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) return;
    end
    total++; bad++;
    $display("FAIL timeout: %0d results outstanding, expected 0", exp_q.size());
    exp_q.delete();
  endtask

  task automatic run(input string name, input logic [2*N-1:0] a, input logic [N-1:0] b,
                     input logic [N-1:0] q_lit, input logic [N-1:0] r_lit, input bit e_lit);
    start_op(a, b);
    wait_done();
    check({name, "_q"},   outQ,  q_lit);
    check({name, "_r"},   outR,  r_lit);
    check({name, "_err"}, errDR, e_lit);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; startDR = 1'b0; Dvd = '0; Dvs = '0;
    #3 rst = 1'b0;
    #10;
    check("rst_busy",  busy,    1'b0);
    check("rst_ready", readyDR, 1'b0);
    check("rst_err",   errDR,   1'b0);
    check("rst_q",     outQ,    16'h0);
    check("rst_r",     outR,    16'h0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    run("pos_1000_7",  32'd1000,      16'd7,      16'd142,  16'd6,    1'b0);
    run("neg_1000_7",  32'hFFFFFC18,  16'd7,      16'hFF72, 16'hFFFA, 1'b0);
    run("neg_min_q",   32'hFFFF8000,  16'd1,      16'h8000, 16'h0,    1'b0);
    run("pos_ovf_fix", 32'h00008000,  16'd1,      16'h0,    16'h0,    1'b1);
    run("pre_ovf",     32'h00010000,  16'd1,      16'h0,    16'h0,    1'b1);
    run("div_zero",    32'd5,         16'd0,      16'h0,    16'h0,    1'b1);
    run("after_zero",  32'd100,       16'd10,     16'd10,   16'h0,    1'b0);
    // -1234 * 567 = -699678 = 32'hFFF552E2
    run("round_trip",  32'hFFF552E2,  16'd567,    16'hFB2E, 16'h0,    1'b0);
    run("pos_neg",     32'd7,         16'hFFFE,   16'hFFFD, 16'd1,    1'b0);
    run("pos_max_q",   32'h3FFF0001,  16'h7FFF,   16'h7FFF, 16'h0,    1'b0);
    run("min_by_m1",   32'h80000000,  16'hFFFF,   16'h0,    16'h0,    1'b1);

    // start pulse and operand changes mid-operation must be ignored
    start_op(32'd1000, 16'd7);
    repeat (5) @(negedge clk);
    #1 Dvd = 32'd1; Dvs = 16'd1; startDR = 1'b1;
    @(posedge clk);
    #1 startDR = 1'b0; Dvd = 32'hDEAD_BEEF; Dvs = 16'h0;
    wait_done();
    check("ignore_start_q", outQ, 16'd142);
    check("ignore_start_r", outR, 16'd6);

    // back-to-back: second start issued in the ready cycle
    start_op(32'd100, 16'd10);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (readyDR) seen = 1'b1;
    end
    check("b2b_first_ready", seen, 1'b1);
    if (seen) begin
      start_op(32'hFFFFFFF9, 16'd2);
      wait_done();
      check("b2b_q", outQ, 16'hFFFD);
      check("b2b_r", outR, 16'hFFFF);
    end

    // asynchronous reset in the middle of iteration
    start_op(32'd1000, 16'd7);
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_q",     outQ,    16'h0);
    check("midrst_r",     outR,    16'h0);
    check("midrst_busy",  busy,    1'b0);
    check("midrst_ready", readyDR, 1'b0);
    exp_q.delete();
    @(negedge clk); rst = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    run("after_rst",   32'd100,       16'd10,     16'd10,   16'h0,    1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
